// File: rtl/sim_scheduler_pkg.sv
// Shared board/speed geometry and the scheduler state encoding.
package sim_scheduler_pkg;

    localparam int LOG_BOARD_SIZE = 6;
    localparam int BOARD_SIZE     = 1 << LOG_BOARD_SIZE;
    localparam int LOG_MAX_SPEED  = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_EDIT
    } sched_state_t;

endpackage

// File: rtl/sim_scheduler_rise_detect.sv
// Rising-edge detector: rise_out is high while level_in is 1 and was 0 last cycle.
module rise_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic level_in,
    output logic rise_out
);

    logic level_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_in;
        end
    end

    assign rise_out = level_in & ~level_q;

endmodule

// File: rtl/sim_scheduler.sv
// Paces generation starts from the speed setting and serialises user cell
// toggles against generations for access to the board memory.
module sim_scheduler
    import sim_scheduler_pkg::*;
#(
    parameter int LOG_TICK_MAX = 25,
    parameter int GEN_COUNT_W  = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      run_in,
    input  logic                      step_in,
    input  logic                      click_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
    input  logic [LOG_MAX_SPEED-1:0]  speed_in,
    input  logic                      gen_done_in,
    input  logic                      toggle_ready_in,
    output logic                      gen_start_out,
    output logic                      toggle_valid_out,
    output logic [LOG_BOARD_SIZE-1:0] toggle_x_out,
    output logic [LOG_BOARD_SIZE-1:0] toggle_y_out,
    output logic                      busy_out,
    output logic [GEN_COUNT_W-1:0]    gen_count_out
);

    sched_state_t              state_q;
    logic                      click_rise;
    logic                      step_rise;
    logic                      toggle_pending_q;
    logic                      step_pending_q;
    logic [LOG_TICK_MAX-1:0]   pace_q;
    logic [LOG_TICK_MAX-1:0]   threshold;
    logic                      tick_due;
    logic                      gen_start_q;
    logic                      toggle_valid_q;
    logic                      busy_q;
    logic [LOG_BOARD_SIZE-1:0] toggle_x_q;
    logic [LOG_BOARD_SIZE-1:0] toggle_y_q;
    logic [GEN_COUNT_W-1:0]    gen_count_q;

    rise_detect u_click_rise (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .level_in (click_in),
        .rise_out (click_rise)
    );

    rise_detect u_step_rise (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .level_in (step_in),
        .rise_out (step_rise)
    );

    // Higher speed shortens the period; a speed change applies to the running count.
    assign threshold = {LOG_TICK_MAX{1'b1}} >> speed_in;
    assign tick_due  = (pace_q >= threshold);

    // Toggle handshake: toggle_valid_out rises only out of S_IDLE and stays high,
    // with toggle_x/y frozen, until the cycle where toggle_ready_in is also high.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q          <= S_IDLE;
            toggle_pending_q <= 1'b0;
            step_pending_q   <= 1'b0;
            pace_q           <= '0;
            gen_start_q      <= 1'b0;
            toggle_valid_q   <= 1'b0;
            busy_q           <= 1'b0;
            toggle_x_q       <= '0;
            toggle_y_q       <= '0;
            gen_count_q      <= '0;
        end else begin
            gen_start_q <= 1'b0;
            if (!(&pace_q)) begin
                pace_q <= pace_q + 1'b1;
            end
            // Single-entry request slots: a new edge while one is held is lost.
            if (click_rise && !toggle_pending_q) begin
                toggle_pending_q <= 1'b1;
                toggle_x_q       <= cursor_x_in;
                toggle_y_q       <= cursor_y_in;
            end
            if (step_rise && !run_in) begin
                step_pending_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (toggle_pending_q) begin
                        state_q        <= S_EDIT;
                        toggle_valid_q <= 1'b1;
                        busy_q         <= 1'b1;
                    end else if ((run_in && tick_due) || step_pending_q) begin
                        state_q        <= S_GEN;
                        gen_start_q    <= 1'b1;
                        step_pending_q <= 1'b0;
                        pace_q         <= '0;
                        busy_q         <= 1'b1;
                    end
                end
                S_GEN: begin
                    if (gen_done_in) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        gen_count_q <= gen_count_q + 1'b1;
                    end
                end
                S_EDIT: begin
                    if (toggle_ready_in) begin
                        state_q          <= S_IDLE;
                        toggle_valid_q   <= 1'b0;
                        toggle_pending_q <= 1'b0;
                        busy_q           <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gen_start_out    = gen_start_q;
    assign toggle_valid_out = toggle_valid_q;
    assign toggle_x_out     = toggle_x_q;
    assign toggle_y_out     = toggle_y_q;
    assign busy_out         = busy_q;
    assign gen_count_out    = gen_count_q;

endmodule
